// File: rtl/dsa_stream_feeder.sv
// rtl/dsa_stream_feeder.sv - memory-mapped operand feeder and result FIFO for a three-operand FP IP
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   S_DEVICE_*                single-cycle strobe bus; ready/data returned the following cycle
//   a/b/c_valid_o, a/b/c_data_o  staged operands and one-cycle launch pulses to the IP
//   r_valid_i, r_data_i       results returned by the IP
module dsa_stream_feeder #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'hC4000000),
  parameter int              RES_DEPTH = 8,
  parameter int              CNT_W     = $clog2(RES_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            S_DEVICE_strobe_i,
  input  logic [XLEN-1:0] S_DEVICE_addr_i,
  input  logic            S_DEVICE_rw_i,
  input  logic [XLEN-1:0] S_DEVICE_data_i,
  output logic            S_DEVICE_ready_o,
  output logic [XLEN-1:0] S_DEVICE_data_o,
  output logic            a_valid_o,
  output logic            b_valid_o,
  output logic            c_valid_o,
  output logic [XLEN-1:0] a_data_o,
  output logic [XLEN-1:0] b_data_o,
  output logic [XLEN-1:0] c_data_o,
  input  logic            r_valid_i,
  input  logic [XLEN-1:0] r_data_i
);

  localparam int PTR_W = $clog2(RES_DEPTH);

  localparam logic [XLEN-1:0] OFF_RESULT = XLEN'(32'h00);
  localparam logic [XLEN-1:0] OFF_IN1    = XLEN'(32'h04);
  localparam logic [XLEN-1:0] OFF_IN2    = XLEN'(32'h08);
  localparam logic [XLEN-1:0] OFF_IN3    = XLEN'(32'h0C);
  localparam logic [XLEN-1:0] OFF_CTRL   = XLEN'(32'h10);
  localparam logic [XLEN-1:0] OFF_STATUS = XLEN'(32'h14);

  // Staged operands
  logic [XLEN-1:0] in1_q, in2_q, in3_q;
  logic            valid_q;

  // Result FIFO
  logic [XLEN-1:0]  mem_q [RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] res_count_q;
  logic [CNT_W-1:0] inflight_q;

  // Sticky error flags
  logic ovf_q, udf_q;
  logic ovf_n, udf_n;

  // Bus response
  logic            ready_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] rd_mux;
  logic [XLEN-1:0] status;

  // Decode
  logic [XLEN-1:0] off;
  logic            rd_acc, wr_acc;
  logic            ctrl_wr, clr_err, flush, launch_req, launch_ok;
  logic            pop_req, pop_ok, push_ok, push_drop, inflight_dec;
  logic            res_empty, res_full;
  logic [CNT_W-1:0] cnt_eff;
  logic [CNT_W:0]   credit_sum;

  assign off    = S_DEVICE_addr_i - BASE_ADDR;
  assign rd_acc = S_DEVICE_strobe_i & ~S_DEVICE_rw_i;
  assign wr_acc = S_DEVICE_strobe_i &  S_DEVICE_rw_i;

  assign ctrl_wr    = wr_acc & (off == OFF_CTRL);
  assign clr_err    = ctrl_wr & S_DEVICE_data_i[2];
  assign flush      = ctrl_wr & S_DEVICE_data_i[1];
  assign launch_req = ctrl_wr & S_DEVICE_data_i[0];

  assign res_empty = (res_count_q == '0);
  assign res_full  = (res_count_q == CNT_W'(RES_DEPTH));

  // A flush in the same write empties the FIFO before the credit check.
  assign cnt_eff    = flush ? '0 : res_count_q;
  assign credit_sum = {1'b0, inflight_q} + {1'b0, cnt_eff};
  assign launch_ok  = launch_req & (credit_sum < (CNT_W+1)'(RES_DEPTH));

  // Only one bus access per cycle, so a pop never coincides with a flush.
  assign pop_req   = rd_acc & (off == OFF_RESULT);
  assign pop_ok    = pop_req & ~res_empty;
  assign push_ok   = r_valid_i & ~flush & (~res_full | pop_ok);
  assign push_drop = r_valid_i & ~flush & res_full & ~pop_ok;

  // In-flight counter saturates at zero for results we did not launch.
  assign inflight_dec = r_valid_i & (inflight_q != '0);

  always_comb begin
    status        = '0;
    status[0]     = res_empty;
    status[1]     = res_full;
    status[2]     = (inflight_q != '0);
    status[3]     = ovf_q;
    status[4]     = udf_q;
    status[15:8]  = 8'(res_count_q);
    status[23:16] = 8'(inflight_q);
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_RESULT: rd_mux = res_empty ? '0 : mem_q[rd_ptr_q];
      OFF_IN1:    rd_mux = in1_q;
      OFF_IN2:    rd_mux = in2_q;
      OFF_IN3:    rd_mux = in3_q;
      OFF_STATUS: rd_mux = status;
      default:    rd_mux = '0;
    endcase
  end

  // CLR_ERR is applied before any error raised by the same cycle's events.
  always_comb begin
    ovf_n = clr_err ? 1'b0 : ovf_q;
    udf_n = clr_err ? 1'b0 : udf_q;
    if ((launch_req & ~launch_ok) | push_drop) ovf_n = 1'b1;
    if (pop_req & res_empty)                   udf_n = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      in3_q       <= '0;
      valid_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      res_count_q <= '0;
      inflight_q  <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      ready_q <= S_DEVICE_strobe_i;
      if (rd_acc) rdata_q <= rd_mux;

      if (wr_acc && off == OFF_IN1) in1_q <= S_DEVICE_data_i;
      if (wr_acc && off == OFF_IN2) in2_q <= S_DEVICE_data_i;
      if (wr_acc && off == OFF_IN3) in3_q <= S_DEVICE_data_i;

      valid_q    <= launch_ok;
      inflight_q <= inflight_q + CNT_W'(launch_ok) - CNT_W'(inflight_dec);

      if (flush) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        res_count_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        res_count_q <= res_count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end

      ovf_q <= ovf_n;
      udf_q <= udf_n;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= r_data_i;
  end

  assign S_DEVICE_ready_o = ready_q;
  assign S_DEVICE_data_o  = rdata_q;
  assign a_valid_o        = valid_q;
  assign b_valid_o        = valid_q;
  assign c_valid_o        = valid_q;
  assign a_data_o         = in1_q;
  assign b_data_o         = in2_q;
  assign c_data_o         = in3_q;

endmodule

// File: doc/dsa_stream_feeder.md
Name: dsa_stream_feeder

Overview:
- Memory-mapped feeder between the Aquila core bus and a three-operand floating-point IP (fused multiply-add class), parametrised in data width, base address and result buffering depth.
- Unlike a free-running feeder, operands are staged in registers and issued to the IP only on an explicit launch command, as single-cycle valid pulses.
- Results are captured into a result FIFO. Credit-based flow control bounds in-flight operations so that no result is ever lost.
- Status and sticky error flags are software-visible.

Parameters:
- XLEN, 32, bus and operand width.
- BASE_ADDR, 32'hC4000000, base of the 6-word register window.
- RES_DEPTH, 8, result FIFO depth; power of two, 2..64.
- CNT_W, $clog2(RES_DEPTH)+1, width of the occupancy and in-flight counters.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- S_DEVICE_strobe_i  in  1  one-cycle access request
- S_DEVICE_addr_i  in  XLEN  byte address
- S_DEVICE_rw_i  in  1  1 = write, 0 = read
- S_DEVICE_data_i  in  XLEN  write data
- S_DEVICE_ready_o  out  1  access-complete pulse
- S_DEVICE_data_o  out  XLEN  read data, valid while ready is high
- a_valid_o / b_valid_o / c_valid_o  out  1  operand valid pulses to IP
- a_data_o / b_data_o / c_data_o  out  XLEN  staged operands
- r_valid_i  in  1  result valid from IP
- r_data_i  in  XLEN  result data

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 RESULT (R): pops the result FIFO.
  - 0x04, 0x08, 0x0C IN1, IN2, IN3 (R/W): staged operands; a/b/c_data_o drive these registers continuously.
  - 0x10 CTRL (W): bit0 LAUNCH, bit1 FLUSH (clear result FIFO), bit2 CLR_ERR.
  - 0x14 STATUS (R):
    - [0] res_empty
    - [1] res_full
    - [2] busy (inflight != 0)
    - [3] ovf sticky
    - [4] udf sticky
    - [15:8] res_count
    - [23:16] inflight
    - other bits 0.
- Reads of CTRL and unmapped offsets return 0. Writes to unmapped offsets are ignored.
- Bus handshake:
  - Every strobe, mapped or not, produces S_DEVICE_ready_o high for exactly one cycle, the cycle after strobe.
  - S_DEVICE_data_o is registered and valid in that same cycle; it holds its last value otherwise.
  - No back-pressure; a strobe is accepted every cycle.
- Reset values:
  - S_DEVICE_ready_o = 0, S_DEVICE_data_o = 0.
  - Operand registers = 0; a/b/c_valid_o = 0.
  - FIFO empty; inflight = 0; ovf = udf = 0.
- Launch:
  - Accepted when inflight + res_count < RES_DEPTH. In that case, a/b/c_valid_o are all high for exactly one cycle, the cycle after the CTRL write, and inflight increments.
  - If the credit check fails, no pulse is issued and ovf is set.
  - Operand writes in the same cycle as the launch pulse do not alter the pulsed data; data is held from the cycle of the CTRL write.
- Result capture:
  - r_valid_i pushes r_data_i into the FIFO and decrements inflight.
  - r_valid_i while inflight == 0: inflight stays 0 (saturating); the result is still pushed if the FIFO is not full.
  - Push while full: data is dropped and ovf is set.
- RESULT read:
  - Non-empty: returns the head entry and pops it.
  - Empty: returns 0, sets udf, and leaves the FIFO state unchanged.
- Simultaneous events:
  - Push and pop in the same cycle: res_count unchanged, FIFO order preserved. When empty, the pop reads as underflow and the push still lands.
  - Launch and r_valid_i in the same cycle: inflight unchanged.
  - FLUSH together with a push: flush wins; the arriving result is discarded, but inflight still decrements.
  - FLUSH does not cancel in-flight operations.
  - Multiple CTRL bits in one write: effects are applied in the order CLR_ERR, FLUSH, LAUNCH. The launch credit check uses res_count = 0 when FLUSH is also set.
- Pointers wrap modulo RES_DEPTH. res_count ranges 0..RES_DEPTH.
- Reset asserted mid-operation:
  - Everything returns to reset values on the next edge; any pending valid pulse is suppressed.
  - Results arriving after reset for pre-reset launches are pushed, with inflight saturating at 0.

Test Plan:
- Write IN1=3F800000, IN2=40000000, IN3=40400000, then CTRL=1 → one-cycle valids with those data. Model the IP returning 40A00000 after 5 cycles. STATUS bit2 is 1 during the wait and 0 after. RESULT read returns 40A00000; STATUS then shows res_empty=1.
- 8 launches with no reads (RES_DEPTH=8), then a 9th launch → no valid pulse on the 9th, ovf=1, inflight + count = 8. After 8 results, 8 reads return them in order. CLR_ERR then gives STATUS=0x00000001.
- Read RESULT when empty → data 0, ready pulse, udf=1, res_count still 0.
- r_valid_i in the same cycle as a RESULT pop with count=3 → count stays 3; subsequent reads return entries in FIFO order across pointer wrap.
- CTRL=0x3 (FLUSH+LAUNCH) with a full FIFO → FIFO empties and the launch is accepted. CTRL=0x2 in the same cycle as r_valid_i → that result is discarded and inflight decrements.
- Assert rst_i for 1 cycle mid-launch → valids stay 0, all outputs return to reset values, STATUS reads 0x00000001.
